// File: rtl/counter_cmd_if.sv
// Command channel into the counter sequencer: valid/ready handshake carrying op, data and run length.
interface counter_cmd_if #(
  parameter int unsigned DATA_W = 5,
  parameter int unsigned LEN_W  = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [DATA_W-1:0] cmd_data;
  logic [LEN_W-1:0]  cmd_len;

  modport master (output cmd_valid, cmd_op, cmd_data, cmd_len, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_data, cmd_len, output cmd_ready);
endinterface

// File: rtl/counter_cmd_seq.sv
// Buffers LOAD/UP/DOWN/HOLD commands in a small FIFO and replays them as cycle-exact
// load/mode/data control for the downstream mod-12 counter, freezing it between commands.
module counter_cmd_seq #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned DATA_W  = 5,
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned MAX_VAL = 11
) (
  input  logic              clk,
  input  logic              rst,
  counter_cmd_if.slave      cmd,
  input  logic [DATA_W-1:0] count_in,
  output logic              load,
  output logic              mode,
  output logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [1:0] {OP_LOAD = 2'b00, OP_UP = 2'b01, OP_DOWN = 2'b10, OP_HOLD = 2'b11} op_e;
  typedef enum logic {S_IDLE = 1'b0, S_EXEC = 1'b1} state_e;

  typedef struct packed {
    logic [1:0]        op;
    logic [DATA_W-1:0] data;
    logic [LEN_W-1:0]  len;
  } cmd_t;

  cmd_t              mem [DEPTH];
  cmd_t              head;
  logic [PW-1:0]     wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic              empty, full, illegal, accept, push, pop;
  state_e            state, state_nxt;
  op_e               cur_op;
  logic [DATA_W-1:0] cur_data;
  logic [LEN_W-1:0]  rem_cnt, rem_nxt;
  logic              mode_r;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign cmd.cmd_ready = !full;
  assign accept        = cmd.cmd_valid && !full;
  assign illegal       = (cmd.cmd_op == OP_LOAD) && (cmd.cmd_data > DATA_W'(MAX_VAL));
  assign push          = accept && !illegal;
  assign head          = mem[rd_ptr[AW-1:0]];

  assign wr_ptr_nxt = wr_ptr + PW'(push);
  assign rd_ptr_nxt = rd_ptr + PW'(pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= '{op: cmd.cmd_op, data: cmd.cmd_data, len: cmd.cmd_len};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // A finishing command hands straight over to the next queued one, so no gap cycle.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (rem_cnt == LEN_W'(1)) begin
          if (!empty) pop = 1'b1;
          else        state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Default is HOLD: reload the counter with its own value.
  always_comb begin
    load = 1'b1;
    mode = mode_r;
    data = count_in;
    if (state == S_EXEC) begin
      case (cur_op)
        OP_LOAD: data = cur_data;
        OP_UP: begin
          load = 1'b0;
          mode = 1'b1;
          data = '0;
        end
        OP_DOWN: begin
          load = 1'b0;
          mode = 1'b0;
          data = '0;
        end
        default: ;
      endcase
    end
    if (rst) begin
      load = 1'b0;
      mode = 1'b0;
      data = '0;
    end
  end

  // Run length 0 still executes once; LOAD is always a single cycle.
  always_comb begin
    rem_nxt = rem_cnt;
    if (pop) begin
      if ((head.op == OP_LOAD) || (head.len == '0)) rem_nxt = LEN_W'(1);
      else                                           rem_nxt = head.len;
    end else if (state == S_EXEC) begin
      rem_nxt = rem_cnt - LEN_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rem_cnt  <= '0;
      cur_op   <= OP_LOAD;
      cur_data <= '0;
      mode_r   <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
      rem_cnt <= rem_nxt;
      if (pop) begin
        cur_op   <= op_e'(head.op);
        cur_data <= head.data;
        if (head.op == OP_UP)        mode_r <= 1'b1;
        else if (head.op == OP_DOWN) mode_r <= 1'b0;
      end
      done <= (state_nxt == S_EXEC) && (rem_nxt == LEN_W'(1));
      busy <= (state_nxt == S_EXEC) || (wr_ptr_nxt != rd_ptr_nxt);
      err  <= accept && illegal;
    end
  end

endmodule

// File: tb/tb_counter_cmd_seq.sv
// Bench for counter_cmd_seq: drives commands, closes the loop through a mod-12 counter model,
// and checks every cycle against a queue of expected control words.
module tb_counter_cmd_seq;
  localparam int unsigned DW = 5;
  localparam int unsigned LW = 8;
  localparam logic [1:0] OP_LOAD = 2'd0, OP_UP = 2'd1, OP_DOWN = 2'd2, OP_HOLD = 2'd3;

  logic          clk;
  logic          rst;
  logic [DW-1:0] count;
  logic          load, mode, busy, done, err;
  logic [DW-1:0] data;

  counter_cmd_if #(.DATA_W(DW), .LEN_W(LW)) bus ();

  counter_cmd_seq #(.DEPTH(4), .DATA_W(DW), .LEN_W(LW), .MAX_VAL(11)) dut (
    .clk(clk), .rst(rst), .cmd(bus), .count_in(count),
    .load(load), .mode(mode), .data(data), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mod-12 up/down counter fed by the sequencer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       count <= '0;
    else if (load) count <= data;
    else if (mode) count <= (count == 5'd11) ? 5'd0 : count + 5'd1;
    else           count <= (count == 5'd0) ? 5'd11 : count - 5'd1;
  end

  typedef struct {
    logic          load;
    logic          mode;
    logic          hold;
    logic          done;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct {
    logic [1:0]    op;
    logic [DW-1:0] data;
    logic [LW-1:0] len;
    logic [DW-1:0] exp_count;
  } vec_t;

  exp_t exp_q[$];
  vec_t vec[12];
  int   checks   = 0;
  int   failures = 0;
  int   dn_cnt   = 0;
  logic mon_en;
  logic mode_tail;
  logic err_pend;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected control words for an accepted command, appended after whatever is still pending.
  task automatic record(input logic [1:0] op, input logic [DW-1:0] d, input logic [LW-1:0] l);
    int   n;
    exp_t e;
    if (op == OP_LOAD && d > 5'd11) begin
      err_pend = 1'b1;
      return;
    end
    if (exp_q.size() == 0)
      exp_q.push_back('{load: 1'b1, mode: mode_tail, hold: 1'b1, done: 1'b0, data: '0});
    n = (op == OP_LOAD || l == '0) ? 1 : int'(l);
    if (op == OP_UP)        mode_tail = 1'b1;
    else if (op == OP_DOWN) mode_tail = 1'b0;
    for (int i = 0; i < n; i++) begin
      e.load = (op == OP_LOAD) || (op == OP_HOLD);
      e.mode = mode_tail;
      e.hold = (op == OP_HOLD);
      e.data = (op == OP_LOAD) ? d : '0;
      e.done = (i == n - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic monitor();
    exp_t          e;
    logic          bz;
    logic [DW-1:0] ed;
    forever begin
      @(negedge clk);
      if (mon_en && !rst) begin
        if (exp_q.size() > 0) begin
          e  = exp_q.pop_front();
          bz = 1'b1;
        end else begin
          e  = '{load: 1'b1, mode: mode_tail, hold: 1'b1, done: 1'b0, data: '0};
          bz = 1'b0;
        end
        ed = e.hold ? count : e.data;
        check("cyc_load", 32'(load), 32'(e.load));
        check("cyc_mode", 32'(mode), 32'(e.mode));
        check("cyc_data", 32'(data), 32'(ed));
        check("cyc_done", 32'(done), 32'(e.done));
        check("cyc_busy", 32'(busy), 32'(bz));
        check("cyc_err",  32'(err),  32'(err_pend));
        err_pend = 1'b0;
        if (done) dn_cnt++;
      end
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [DW-1:0] d, input logic [LW-1:0] l);
    logic rdy;
    bit   ok;
    ok = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    bus.cmd_len   = l;
    for (int i = 0; i < 100 && !ok; i++) begin
      rdy = bus.cmd_ready;
      @(posedge clk);
      if (rdy) ok = 1'b1;
      else     @(negedge clk);
    end
    if (ok) record(op, d, l);
    else    check("send_timeout", 32'(ok), 32'd1);
  endtask

  task automatic release_bus();
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1'b1;
    end
    if (!ok) check("drain_timeout", 32'(ok), 32'd1);
  endtask

  int base;

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    bus.cmd_data  = '0;
    bus.cmd_len   = '0;
    mon_en    = 1'b0;
    mode_tail = 1'b0;
    err_pend  = 1'b0;

    vec[0]  = '{OP_LOAD, 5'd9,  8'd0,   5'd9};
    vec[1]  = '{OP_UP,   5'd0,  8'd4,   5'd1};
    vec[2]  = '{OP_LOAD, 5'd1,  8'd0,   5'd1};
    vec[3]  = '{OP_DOWN, 5'd0,  8'd3,   5'd10};
    vec[4]  = '{OP_LOAD, 5'd12, 8'd0,   5'd10};
    vec[5]  = '{OP_LOAD, 5'd7,  8'd5,   5'd7};
    vec[6]  = '{OP_HOLD, 5'd3,  8'd0,   5'd7};
    vec[7]  = '{OP_UP,   5'd0,  8'd0,   5'd8};
    vec[8]  = '{OP_DOWN, 5'd0,  8'd255, 5'd5};
    vec[9]  = '{OP_LOAD, 5'd11, 8'd0,   5'd11};
    vec[10] = '{OP_UP,   5'd0,  8'd1,   5'd0};
    vec[11] = '{OP_DOWN, 5'd0,  8'd1,   5'd11};

    fork
      monitor();
    join_none

    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_load",  32'(load), 32'd0);
    check("rst_mode",  32'(mode), 32'd0);
    check("rst_data",  32'(data), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_err",   32'(err),  32'd0);
    check("rst_ready", 32'(bus.cmd_ready), 32'd1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_count", 32'(count), 32'd0);

    for (int i = 0; i < 12; i++) begin
      send(vec[i].op, vec[i].data, vec[i].len);
      release_bus();
      wait_idle(400);
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vec[i].exp_count));
      check($sformatf("vec%0d_ready", i), 32'(bus.cmd_ready), 32'd1);
    end

    // Back-to-back HOLDs fill the FIFO behind the executing one.
    base = dn_cnt;
    for (int i = 0; i < 5; i++) send(OP_HOLD, 5'd0, 8'd10);
    @(negedge clk);
    check("bp_ready_full", 32'(bus.cmd_ready), 32'd0);
    send(OP_HOLD, 5'd0, 8'd3);
    check("bp_accept_after_pop", 32'(dn_cnt - base), 32'd1);
    send(OP_LOAD, 5'd20, 8'd0);
    release_bus();
    wait_idle(200);
    check("bp_count", 32'(count), 32'd11);
    check("bp_dones", 32'(dn_cnt - base), 32'd6);

    // Reset in the middle of an UP run with more work queued.
    send(OP_LOAD, 5'd5, 8'd0);
    send(OP_UP, 5'd0, 8'd20);
    send(OP_HOLD, 5'd0, 8'd4);
    release_bus();
    repeat (6) @(negedge clk);
    check("pre_rst_mode", 32'(mode), 32'd1);
    #2 rst = 1'b1;
    mon_en = 1'b0;
    #1;
    check("midrst_load", 32'(load), 32'd0);
    check("midrst_mode", 32'(mode), 32'd0);
    check("midrst_data", 32'(data), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    exp_q.delete();
    mode_tail = 1'b0;
    err_pend  = 1'b0;
    base = dn_cnt;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    mon_en = 1'b1;
    repeat (8) @(negedge clk);
    check("post_rst_count", 32'(count), 32'd0);
    check("post_rst_dones", 32'(dn_cnt - base), 32'd0);
    check("post_rst_ready", 32'(bus.cmd_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
